// File: rtl/dut_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dut_pkg
// Purpose  : Shared types and constants for the lock keypad front-end.
// Revision : 1.0  initial release
// ============================================================================
package dut_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    KP_IDLE     = 2'd0,
    KP_ENTRY    = 2'd1,
    KP_UNLOCKED = 2'd2,
    KP_LOCKOUT  = 2'd3
  } keypad_state;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lock_keypad_timer.sv
`default_nettype none
// ============================================================================
// Module   : lock_timer
// Purpose  : Loadable down-counter that holds at zero; shared by relock and lockout.
// Revision : 1.0  initial release
// ============================================================================
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/lock_keypad.sv
`default_nettype none
// ============================================================================
// Module   : lock_keypad
// Purpose  : Keypad code entry with open/close command pulses, auto-relock and lockout.
// Revision : 1.0  initial release
// ============================================================================
module lock_keypad
  import dut_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter logic [31:0] CODE           = 32'h1234,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          RELOCK_CYCLES  = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_enter,
  input  logic               key_clear,
  input  logic               close_req,
  output logic               open,
  output logic               close,
  output logic               err,
  output logic               lockout
);

  localparam int BW = DIGIT_W * CODE_LEN;
  localparam int CW = $clog2(CODE_LEN + 2);
  localparam int FW = max_int(1, $clog2(MAX_FAILS + 1));
  localparam int TW = max_int(1, $clog2(max_int(LOCKOUT_CYCLES, RELOCK_CYCLES)));

  keypad_state   state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bad_q, bad_d;
  logic [FW-1:0] fails_q, fails_d;
  logic          open_q, open_d;
  logic          close_q, close_d;
  logic          err_q, err_d;

  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_zero;
  logic          pass;
  logic [FW-1:0] fail_next;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  assign pass      = (cnt_q == CW'(CODE_LEN)) && !bad_q && (buf_q == CODE[BW-1:0]);
  assign fail_next = fails_q + FW'(1);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    fails_d = fails_q;
    open_d  = 1'b0;
    close_d = 1'b0;
    err_d   = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;

    case (state_q)
      KP_IDLE, KP_ENTRY: begin
        if (key_clear) begin
          buf_d   = '0;
          cnt_d   = '0;
          bad_d   = 1'b0;
          state_d = KP_IDLE;
        end else if (key_enter) begin
          buf_d = '0;
          cnt_d = '0;
          bad_d = 1'b0;
          if (pass) begin
            open_d  = 1'b1;
            fails_d = '0;
            t_load  = 1'b1;
            t_val   = TW'(RELOCK_CYCLES - 1);
            state_d = KP_UNLOCKED;
          end else begin
            err_d   = 1'b1;
            fails_d = fail_next;
            if (fail_next == FW'(MAX_FAILS)) begin
              t_load  = 1'b1;
              t_val   = TW'(LOCKOUT_CYCLES - 1);
              state_d = KP_LOCKOUT;
            end else begin
              state_d = KP_IDLE;
            end
          end
        end else if (key_valid) begin
          // Oldest digit falls off the top; the newest sits in the low nibble.
          buf_d   = (buf_q << DIGIT_W) | BW'(key_digit);
          cnt_d   = (cnt_q == CW'(CODE_LEN + 1)) ? cnt_q : cnt_q + CW'(1);
          bad_d   = bad_q | (key_digit > DIGIT_W'(9));
          state_d = KP_ENTRY;
        end
      end
      KP_UNLOCKED: begin
        if (close_req || t_zero) begin
          close_d = 1'b1;
          state_d = KP_IDLE;
        end
      end
      KP_LOCKOUT: begin
        if (t_zero) begin
          fails_d = '0;
          state_d = KP_IDLE;
        end
      end
      default: state_d = KP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= KP_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      fails_q <= '0;
      open_q  <= 1'b0;
      close_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      fails_q <= fails_d;
      open_q  <= open_d;
      close_q <= close_d;
      err_q   <= err_d;
    end
  end

  assign open    = open_q;
  assign close   = close_q;
  assign err     = err_q;
  assign lockout = (state_q == KP_LOCKOUT);

endmodule
`default_nettype wire

// File: tb/tb_lock_keypad.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_keypad
// Purpose  : Directed plus randomized bench for lock_keypad against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lock_keypad;

  localparam int          CODE_LEN       = 4;
  localparam logic [31:0] CODE           = 32'h1234;
  localparam int          MAX_FAILS      = 3;
  localparam int          LOCKOUT_CYCLES = 8;
  localparam int          RELOCK_CYCLES  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = '0;
  logic       key_enter = 1'b0;
  logic       key_clear = 1'b0;
  logic       close_req = 1'b0;
  logic       open, close, err, lockout;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  lock_keypad #(
    .CODE_LEN      (CODE_LEN),
    .CODE          (CODE),
    .MAX_FAILS     (MAX_FAILS),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .RELOCK_CYCLES (RELOCK_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_digit(key_digit),
    .key_enter(key_enter),
    .key_clear(key_clear),
    .close_req(close_req),
    .open     (open),
    .close    (close),
    .err      (err),
    .lockout  (lockout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = accepting keys, 1 = unlocked, 2 = locked out.
  int  m_mode = 0, m_left = 0, m_fails = 0, m_len = 0;
  bit  m_bad = 0;
  int  m_digs[$];
  bit  e_open = 0, e_close = 0, e_err = 0, e_lock = 0;

  function automatic bit code_match();
    if (m_len != CODE_LEN || m_bad || m_digs.size() != CODE_LEN) return 1'b0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (m_digs[i] != ((CODE >> (4 * (CODE_LEN - 1 - i))) & 32'hF)) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit ok;
    e_open = 0; e_close = 0; e_err = 0;
    if (rst) begin
      m_mode = 0; m_left = 0; m_fails = 0; m_len = 0; m_bad = 0; m_digs.delete();
    end else if (m_mode == 2) begin
      if (m_left == 0) begin m_mode = 0; m_fails = 0; end
      else m_left--;
    end else if (m_mode == 1) begin
      if (close_req || m_left == 0) begin e_close = 1; m_mode = 0; end
      else m_left--;
    end else if (key_clear) begin
      m_len = 0; m_bad = 0; m_digs.delete();
    end else if (key_enter) begin
      ok = code_match();
      m_len = 0; m_bad = 0; m_digs.delete();
      if (ok) begin
        e_open = 1; m_fails = 0; m_mode = 1; m_left = RELOCK_CYCLES - 1;
      end else begin
        e_err = 1; m_fails++;
        if (m_fails == MAX_FAILS) begin m_mode = 2; m_left = LOCKOUT_CYCLES - 1; end
      end
    end else if (key_valid) begin
      m_len++;
      if (key_digit > 9) m_bad = 1;
      m_digs.push_back(int'(key_digit));
      if (m_digs.size() > CODE_LEN) void'(m_digs.pop_front());
    end
    e_lock = (m_mode == 2);
  end

  int n_open = 0, n_close = 0, n_err = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("open", open, e_open);
      check_eq("close", close, e_close);
      check_eq("err", err, e_err);
      check_eq("lockout", lockout, e_lock);
      check_eq("open_close_excl", open & close, 1'b0);
      n_open  += int'(open);
      n_close += int'(close);
      n_err   += int'(err);
    end
  end

  task automatic cyc(input bit v, input logic [3:0] d, input bit en, input bit cl, input bit cr);
    @(negedge clk);
    rst = 0; key_valid = v; key_digit = d; key_enter = en; key_clear = cl; close_req = cr;
  endtask

  task automatic key(input logic [3:0] d); cyc(1, d, 0, 0, 0); endtask
  task automatic enter(); cyc(0, 0, 1, 0, 0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0); endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; key_valid = 0; key_enter = 0; key_clear = 0; close_req = 0;
  endtask

  task automatic good_code();
    key(1); key(2); key(3); key(4); enter();
  endtask

  initial begin
    int o0, c0, e0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Correct code, then auto relock
    o0 = n_open; c0 = n_close; e0 = n_err;
    good_code(); idle(10);
    check_eq("t1_opens", n_open - o0, 1);
    check_eq("t1_closes", n_close - c0, 1);
    check_eq("t1_errs", n_err - e0, 0);

    // Manual close shortly after open, no second close at expiry
    c0 = n_close;
    good_code(); idle(1); cyc(0, 0, 0, 0, 1); idle(10);
    check_eq("t2_closes", n_close - c0, 1);

    // Three failures, lockout, code ignored during lockout
    o0 = n_open; e0 = n_err;
    repeat (3) begin key(1); key(2); key(3); key(5); enter(); end
    good_code(); idle(8);
    check_eq("t3_errs", n_err - e0, 3);
    check_eq("t3_no_open", n_open - o0, 0);
    good_code(); idle(8);
    check_eq("t3_open_after", n_open - o0, 1);

    // Overflow, bad digit, cleared entry
    e0 = n_err; o0 = n_open;
    key(1); key(2); key(3); key(4); key(4); enter();
    key(1); key(2); key(4'hA); key(4); enter();
    key(9); key(9); cyc(0, 0, 0, 1, 0);
    good_code(); idle(8);
    check_eq("t4_errs", n_err - e0, 2);
    check_eq("t4_opens", n_open - o0, 1);

    // Enter beats valid; clear beats enter
    e0 = n_err;
    key(1); key(2); key(3); cyc(1, 4, 1, 0, 0);
    key(1); cyc(0, 0, 1, 1, 0); idle(3);
    check_eq("t5_errs", n_err - e0, 1);

    // Reset while unlocked and while locked out
    do_reset(); idle(1);
    good_code(); idle(1); do_reset(); idle(8);
    repeat (3) begin key(7); enter(); end
    idle(2); do_reset(); idle(2);
    key(7); enter(); idle(3);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 10) begin
        for (int k = 0; k < $urandom_range(1, 8); k++)
          cyc($urandom_range(0, 1), 4'($urandom_range(0, 11)), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
      end else if (r < 16) begin
        good_code();
      end else if (r < 19) begin
        idle($urandom_range(1, 10));
      end else begin
        do_reset();
      end
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
